// File: rtl/signed_sub_16b.sv
// Registered two's-complement subtractor (a - b) with overflow, zero, negative,
// unsigned-borrow flags and a sticky overflow status bit.
module signed_sub_16b #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sticky_clr,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             zero,
  output logic             negative,
  output logic             borrow,
  output logic             sticky_ovf
);

  localparam int unsigned Msb = WIDTH - 1;

  logic [WIDTH-1:0] nb;
  logic [WIDTH-1:0] diff;
  logic             ovf_d;
  logic             zero_d;
  logic             neg_d;
  logic             borrow_d;
  logic             sticky_d;

  logic             valid_q;
  logic [WIDTH-1:0] result_q;
  logic             ovf_q;
  logic             zero_q;
  logic             neg_q;
  logic             borrow_q;
  logic             sticky_q;

  // Overflow is judged against the negated subtrahend, so b = MIN yields
  // overflow = a[MSB] rather than the mathematically exact answer.
  always_comb begin
    nb       = ~b + {{(WIDTH-1){1'b0}}, 1'b1};
    diff     = a + nb;
    ovf_d    = (a[Msb] == nb[Msb]) && (diff[Msb] != a[Msb]);
    zero_d   = (diff == '0);
    neg_d    = diff[Msb];
    borrow_d = (a < b);
  end

  // Set has priority over a same-cycle clear.
  always_comb begin
    sticky_d = sticky_q;
    if (in_valid && ovf_d) begin
      sticky_d = 1'b1;
    end else if (sticky_clr) begin
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      borrow_q <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      valid_q  <= in_valid;
      sticky_q <= sticky_d;
      if (in_valid) begin
        result_q <= diff;
        ovf_q    <= ovf_d;
        zero_q   <= zero_d;
        neg_q    <= neg_d;
        borrow_q <= borrow_d;
      end
    end
  end

  assign out_valid  = valid_q;
  assign result     = result_q;
  assign overflow   = ovf_q;
  assign zero       = zero_q;
  assign negative   = neg_q;
  assign borrow     = borrow_q;
  assign sticky_ovf = sticky_q;

endmodule

// File: tb/tb_signed_sub_16b.sv
// Scoreboard bench for signed_sub_16b: stimulus pushes expected responses,
// a negedge monitor pops and compares whenever a result is due.
module tb_signed_sub_16b;

  localparam int unsigned W = 16;

  typedef struct packed {
    logic [W-1:0] r;
    logic         o;
    logic         z;
    logic         n;
    logic         bw;
    logic         s;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         sticky_clr = 1'b0;
  logic         out_valid;
  logic [W-1:0] result;
  logic         overflow;
  logic         zero;
  logic         negative;
  logic         borrow;
  logic         sticky_ovf;

  exp_t         sb[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  logic         stk = 1'b0;
  logic [W-1:0] last_r = '0;
  logic         mon_en = 1'b0;

  signed_sub_16b #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .a          (a),
    .b          (b),
    .sticky_clr (sticky_clr),
    .out_valid  (out_valid),
    .result     (result),
    .overflow   (overflow),
    .zero       (zero),
    .negative   (negative),
    .borrow     (borrow),
    .sticky_ovf (sticky_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: one entry is due at every negedge that follows an issuing edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check("out_valid", {31'd0, out_valid}, 32'd1);
        check("result/flags", {11'd0, result, overflow, zero, negative, borrow, sticky_ovf},
              {11'd0, e});
      end else begin
        check("idle out_valid", {31'd0, out_valid}, 32'd0);
      end
    end
  end

  task automatic issue_exp(input logic [W-1:0] va, input logic [W-1:0] vb, input logic clr,
                           input logic [W-1:0] er, input logic eo, input logic ez,
                           input logic en, input logic ebw);
    exp_t e;
    @(negedge clk);
    #1;
    in_valid   = 1'b1;
    a          = va;
    b          = vb;
    sticky_clr = clr;
    stk        = eo ? 1'b1 : (clr ? 1'b0 : stk);
    e          = '{r: er, o: eo, z: ez, n: en, bw: ebw, s: stk};
    last_r     = er;
    sb.push_back(e);
  endtask

  // Reference: integer difference; flag is exact overflow except b = MIN,
  // where the defined flag is simply a < 0.
  task automatic issue_model(input int sa, input int sbv, input logic clr);
    int           d;
    logic         o;
    logic [W-1:0] r;
    d = sa - sbv;
    r = W'(d);
    if (sbv == -32768) o = (sa < 0);
    else               o = (d > 32767) || (d < -32768);
    issue_exp(W'(sa), W'(sbv), clr, r, o, (r == '0), r[W-1],
              ({1'b0, W'(sa)} < {1'b0, W'(sbv)}));
  endtask

  task automatic idle();
    @(negedge clk);
    #1;
    in_valid   = 1'b0;
    sticky_clr = 1'b0;
  endtask

  int vals[9] = '{0, 1, -1, 32767, -32768, 32766, -32767, 16384, -16384};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset sticky", {31'd0, sticky_ovf}, 32'd0);
    check("reset result", {16'd0, result}, 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Hand-computed boundary vectors.
    issue_exp(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b1);
    issue_exp(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b0);
    issue_exp(16'h4000, 16'hC000, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b1);
    issue_exp(16'h0000, 16'h8000, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b1);
    issue_exp(16'hFFFF, 16'h8000, 1'b0, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b0);
    issue_exp(16'h0005, 16'h0005, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
    issue_exp(16'h0001, 16'h0002, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b1);

    // Sticky: clear, set, hold, clear, set-beats-clear.
    issue_exp(16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
    issue_exp(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b1);
    issue_exp(16'h0005, 16'h0005, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
    issue_exp(16'h0001, 16'h0002, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b1);
    issue_exp(16'h0001, 16'h0002, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b1);
    issue_exp(16'h7FFF, 16'hFFFF, 1'b1, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b1);

    // Back-to-back cross product.
    foreach (vals[i]) begin
      foreach (vals[j]) begin
        issue_model(vals[i], vals[j], 1'b0);
      end
    end

    // Valid gating: changing operands with in_valid low must not disturb outputs.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      in_valid = 1'b0;
      a        = W'(k * 1111 + 7);
      b        = W'(k * 333 + 1);
      @(posedge clk);
      #1;
      check("gated out_valid", {31'd0, out_valid}, 32'd0);
      check("gated result hold", {16'd0, result}, {16'd0, last_r});
    end

    // Asynchronous reset between edges wipes the in-flight result.
    issue_exp(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    sb.delete();
    stk    = 1'b0;
    last_r = '0;
    #1;
    check("async rst out_valid", {31'd0, out_valid}, 32'd0);
    check("async rst result", {16'd0, result}, 32'd0);
    check("async rst flags", {27'd0, overflow, zero, negative, borrow, sticky_ovf}, 32'd0);
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post-release out_valid", {31'd0, out_valid}, 32'd0);
    issue_model(-1, 1, 1'b0);
    idle();

    repeat (3) @(negedge clk);
    check("scoreboard drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/signed_sub_16b.md
Name: signed_sub_16b

Overview:
- Pipelined two's-complement signed subtractor: result = A − B, WIDTH bits (default 16), plus an overflow flag.
- Sits in the datapath ALU slice.
- Inputs are captured with a valid strobe; result and flags are registered with fixed 1-cycle latency.
- A sticky overflow status bit is kept for software polling.

Parameters:
- WIDTH, 16, operand/result width in bits (≥2); all rules below use N = WIDTH, MSB = bit N−1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands valid this cycle.
- a  in  WIDTH  minuend, signed two's complement.
- b  in  WIDTH  subtrahend, signed two's complement.
- sticky_clr  in  1  synchronous clear of sticky_ovf.
- out_valid  out  1  result/flags valid (registered).
- result  out  WIDTH  signed difference, wrapped modulo 2^N.
- overflow  out  1  signed overflow flag for this result.
- zero  out  1  result == 0.
- negative  out  1  result MSB.
- borrow  out  1  unsigned borrow: a < b as unsigned.
- sticky_ovf  out  1  set by any valid overflow; held until cleared.

Behaviour:
- Reset (rst_n low, asynchronous): all outputs and registers go to 0 immediately; out_valid=0, sticky_ovf=0. Release is synchronous to the next clk edge.
- Arithmetic is combinational from a/b, registered on the clk rising edge when in_valid=1:
  - nb = (~b + 1) mod 2^N.
  - result = (a + nb) mod 2^N, which equals (a − b) mod 2^N.
  - overflow = (a[MSB] == nb[MSB]) && (result[MSB] != a[MSB]). This is the defined flag, including the b = MIN edge below.
- b = MIN (−2^(N−1)): nb = MIN, so overflow = a[MSB].
  - a ≥ 0 → overflow = 0 (result wraps, e.g. 0 − MIN = MIN, flag 0).
  - a < 0 → overflow = 1 (e.g. −1 − MIN = MAX, flag 1).
  - Implement exactly this; do not substitute the mathematically exact overflow.
- For b ≠ MIN the flag equals the standard rule: (a[MSB] != b[MSB]) && (result[MSB] != a[MSB]).
- zero, negative and borrow are computed from the same operands and registered together with result.
- Latency is exactly 1 cycle:
  - in_valid at edge k → out_valid=1 with matching data after edge k.
  - in_valid=0 at an edge → out_valid=0; result and flags hold their previous values.
- Back-to-back in_valid every cycle is supported; throughput is 1 per cycle; no backpressure.
- sticky_ovf:
  - Set at an edge where in_valid=1 and the computed overflow=1.
  - sticky_clr=1 clears it at that edge.
  - Simultaneous set and clear → set wins (sticky_ovf=1).
- Reset asserted mid-stream discards the in-flight result; out_valid=0 on the first edge after release unless in_valid=1 at that edge.
- No X propagation: outputs are defined whenever out_valid=1.

Test Plan:
- Directed cross-product over {0, 1, −1, 32767, −32768, 32766, −32767, 16384, −16384} for both a and b (81 pairs), in_valid=1 each cycle.
  - Check one cycle later: result == (a−b) mod 2^16 and overflow per the nb rule.
  - Check out_valid high throughout.
- 32767 − (−1) → result −32768, overflow 1.
- −32768 − 1 → result 32767, overflow 1.
- 16384 − (−16384) → result −32768, overflow 1.
- 0 − (−32768) → result −32768, overflow 0.
- −1 − (−32768) → result 32767, overflow 1.
- 5 − 5 → result 0, zero 1, borrow 0.
- 1 − 2 → result −1, negative 1, borrow 1, overflow 0.
- sticky_ovf:
  - Drive 32767 − (−1); sticky_ovf=1.
  - Follow with non-overflow ops; sticky_ovf stays 1.
  - Pulse sticky_clr; sticky_ovf=0.
  - Pulse sticky_clr in the same cycle as an overflowing op; sticky_ovf=1.
- Valid gating:
  - in_valid=0 with changing a/b → out_valid=0 and result holds its last value.
  - Assert rst_n=0 asynchronously between edges → all outputs read 0 before the next edge.
